data_mem_io_responder: RTL and testbench

- Responder on the processor data-memory port. Takes mem_write, alu_result (address) and write_data from the core, and returns read_data to it.
- Holds word-addressed data RAM plus memory-mapped I/O:
  - LED register
  - free-running cycle counter
  - byte-wide TX FIFO, drained by an external peripheral through a valid/ready handshake
  - status register
- Reads are combinational, so the single-cycle core sees read_data in the same cycle. All state updates occur on the rising clk edge.

---
 rtl/mem_map_pkg.sv | 17 +
 rtl/data_mem_io_responder_tx_fifo.sv | 63 ++++++
 rtl/data_mem_io_responder.sv | 118 +++++++++++
 tb/tb_data_mem_io_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map and status-register layout shared by the data-memory responder.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE   = 32'h0000_1000;

  localparam logic [31:0] ADDR_LED    = MMIO_BASE + 32'h0;
  localparam logic [31:0] ADDR_CYCLES = MMIO_BASE + 32'h4;
  localparam logic [31:0] ADDR_TX     = MMIO_BASE + 32'h8;
  localparam logic [31:0] ADDR_STATUS = MMIO_BASE + 32'hC;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/data_mem_io_responder_tx_fifo.sv
// First-word-fall-through byte FIFO with a sticky overflow flag for rejected pushes.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_mem_io_responder.sv
// Data-memory port responder: word RAM plus LED, cycle counter, TX FIFO and status MMIO.
module data_mem_io_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic [LED_W-1:0]  leds,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_LIMIT = RAM_BASE + 32'(RAM_WORDS * 4);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycles;
  logic [31:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          is_ram;
  logic          hit_led;
  logic          hit_cycles;
  logic          hit_tx;
  logic          hit_status;

  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [31:0]   count_ext;
  logic [31:0]   status_word;

  assign word_addr  = {alu_result[31:2], 2'b00};
  assign ram_idx    = alu_result[AW+1:2];
  assign is_ram     = (alu_result < RAM_LIMIT);
  assign hit_led    = ~is_ram & (word_addr == ADDR_LED);
  assign hit_cycles = ~is_ram & (word_addr == ADDR_CYCLES);
  assign hit_tx     = ~is_ram & (word_addr == ADDR_TX);
  assign hit_status = ~is_ram & (word_addr == ADDR_STATUS);

  // Valid/ready: a byte leaves the FIFO on every rising edge where tx_valid and
  // tx_ready are both high; tx_data holds steady until that transfer happens.
  assign tx_valid = ~fifo_empty;
  assign fifo_pop = tx_valid & tx_ready;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_write & hit_tx),
    .push_data (write_data[7:0]),
    .pop       (fifo_pop),
    .head      (tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf),
    .clr_ovf   (mem_write & hit_status)
  );

  assign count_ext = 32'(fifo_count);

  always_comb begin
    status_word                             = '0;
    status_word[STAT_COUNT_LSB +: 8]        = count_ext[7:0];
    status_word[STAT_OVF]                   = fifo_ovf;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_FULL]                  = fifo_full;
  end

  always_comb begin
    read_data = '0;
    if (is_ram) begin
      read_data = ram[ram_idx];
    end else if (hit_led) begin
      read_data = 32'(leds);
    end else if (hit_cycles) begin
      read_data = cycles;
    end else if (hit_status) begin
      read_data = status_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_write && is_ram) begin
      ram[ram_idx] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds   <= '0;
      cycles <= '0;
    end else begin
      if (mem_write && hit_led) begin
        leds <= write_data[LED_W-1:0];
      end
      if (mem_write && hit_cycles) begin
        cycles <= '0;
      end else begin
        cycles <= cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_io_responder.sv
// Randomized self-checking bench for data_mem_io_responder against a queue-based model.
module tb_data_mem_io_responder;

  localparam int RAM_WORDS  = 256;
  localparam int FIFO_DEPTH = 8;
  localparam int LED_W      = 8;

  logic             clk;
  logic             rst;
  logic             mem_write;
  logic [31:0]      alu_result;
  logic [31:0]      write_data;
  logic [31:0]      read_data;
  logic [LED_W-1:0] leds;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [31:0]      m_ram [RAM_WORDS];
  bit               m_ram_ok [RAM_WORDS];
  logic [LED_W-1:0] m_leds;
  logic [31:0]      m_cycles;
  bit               m_ovf;
  logic [7:0]       exp_q [$];

  data_mem_io_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LED_W      (LED_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_write  (mem_write),
    .alu_result (alu_result),
    .write_data (write_data),
    .read_data  (read_data),
    .leds       (leds),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    logic [31:0] w;
    logic [31:0] st;
    w = a & 32'hFFFF_FFFC;
    known = 1'b1;
    if (a < RAM_WORDS * 4) begin
      known = m_ram_ok[a[9:2]];
      return m_ram[a[9:2]];
    end
    case (w)
      32'h1000: return 32'(m_leds);
      32'h1004: return m_cycles;
      32'h100C: begin
        st = 32'(exp_q.size()) << 8;
        st[2] = m_ovf;
        st[1] = (exp_q.size() == 0);
        st[0] = (exp_q.size() == FIFO_DEPTH);
        return st;
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic rdy);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (r) begin
      m_leds   = '0;
      m_cycles = '0;
      m_ovf    = 1'b0;
      exp_q.delete();
      return;
    end
    m_cycles = (we && a >= RAM_WORDS * 4 && w == 32'h1004) ? 32'h0 : m_cycles + 32'd1;
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (!we) return;
    if (a < RAM_WORDS * 4) begin
      m_ram[a[9:2]]    = d;
      m_ram_ok[a[9:2]] = 1'b1;
    end else if (w == 32'h1000) begin
      m_leds = d[LED_W-1:0];
    end else if (w == 32'h1008) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end else if (w == 32'h100C) begin
      m_ovf = 1'b0;
    end
  endtask

  // One bus cycle: drive at the falling edge, check just after, then advance the model at the rising edge.
  task automatic cycle(input string tag, input logic r, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input bit chk);
    logic [31:0] exp_rd;
    bit          known;
    @(negedge clk);
    rst        = r;
    mem_write  = we;
    alu_result = a;
    write_data = d;
    tx_ready   = rdy;
    #1;
    if (chk) begin
      exp_rd = model_read(a, known);
      if (known) check({tag, ".read_data"}, read_data, exp_rd);
      check({tag, ".leds"}, 32'(leds), 32'(m_leds));
      check({tag, ".tx_valid"}, 32'(tx_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check({tag, ".tx_data"}, 32'(tx_data), 32'(exp_q[0]));
    end
    @(posedge clk);
    model_step(r, we, a, d, rdy);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; mem_write = 1'b0; alu_result = '0; write_data = '0; tx_ready = 1'b0;
    m_leds = '0; m_cycles = '0; m_ovf = 1'b0;
    for (int i = 0; i < RAM_WORDS; i++) m_ram_ok[i] = 1'b0;

    cycle("reset", 1, 0, 32'h0, 32'h0, 0, 0);
    cycle("reset", 1, 0, 32'h0, 32'h0, 0, 0);
    check("reset.tx_data", 32'(tx_data), 32'h0);

    // Counter counts from zero after reset, then a write forces it back
    cycle("cnt0", 0, 0, 32'h1004, 32'h0, 0, 1);
    cycle("cnt1", 0, 0, 32'h1004, 32'h0, 0, 1);
    cycle("cnt2", 0, 0, 32'h1004, 32'h0, 0, 1);
    cycle("status0", 0, 0, 32'h100C, 32'h0, 0, 1);
    cycle("cntwr", 0, 1, 32'h1004, 32'h1234, 0, 1);
    cycle("cntclr", 0, 0, 32'h1004, 32'h0, 0, 1);

    // RAM and aliasing of low address bits
    cycle("ramwr", 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 1);
    cycle("ramrd", 0, 0, 32'h10, 32'h0, 0, 1);
    cycle("ramrd14", 0, 0, 32'h14, 32'h0, 0, 1);
    cycle("ramalias", 0, 1, 32'h13, 32'h1234_5678, 0, 1);
    cycle("ramalias_rd", 0, 0, 32'h10, 32'h0, 0, 1);

    // LED and unmapped space
    cycle("ledwr", 0, 1, 32'h1000, 32'h0000_01A5, 0, 1);
    cycle("ledrd", 0, 0, 32'h1000, 32'h0, 0, 1);
    cycle("unmapwr", 0, 1, 32'h2000, 32'hFFFF_FFFF, 0, 1);
    cycle("unmaprd", 0, 0, 32'h2000, 32'h0, 0, 1);
    cycle("txrd", 0, 0, 32'h1008, 32'h0, 0, 1);

    // Fill, overflow, clear, push+pop at full, drain
    for (int i = 0; i < FIFO_DEPTH; i++) cycle("fill", 0, 1, 32'h1008, 32'h11 + i, 0, 1);
    cycle("full_status", 0, 0, 32'h100C, 32'h0, 0, 1);
    cycle("ovf_push", 0, 1, 32'h1008, 32'h99, 0, 1);
    cycle("ovf_status", 0, 0, 32'h100C, 32'h0, 0, 1);
    cycle("ovf_clr", 0, 1, 32'h100C, 32'h0, 0, 1);
    cycle("clr_status", 0, 0, 32'h100C, 32'h0, 0, 1);
    cycle("pushpop", 0, 1, 32'h1008, 32'h55, 1, 1);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) cycle("drain", 0, 0, 32'h100C, 32'h0, 1, 1);

    // Reset in the middle of activity with a simultaneous push
    for (int i = 0; i < 3; i++) cycle("mid_fill", 0, 1, 32'h1008, 32'hA0 + i, 0, 1);
    cycle("mid_led", 0, 1, 32'h1000, 32'hFF, 0, 1);
    cycle("mid_rst", 1, 1, 32'h1008, 32'h77, 0, 1);
    cycle("post_cnt", 0, 0, 32'h1004, 32'h0, 0, 1);
    cycle("post_status", 0, 0, 32'h100C, 32'h0, 0, 1);
    cycle("post_ram", 0, 0, 32'h10, 32'h0, 0, 1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = $urandom_range(0, RAM_WORDS * 4 - 1);
        3:       a = 32'h1000 | $urandom_range(0, 3);
        4:       a = 32'h1004;
        5, 6:    a = 32'h1008;
        7, 8:    a = 32'h100C;
        default: a = $urandom();
      endcase
      cycle("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), a,
            $urandom(), ($urandom_range(0, 2) == 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
